nv_ram_rws_fifo_ctrl_64x256: RTL and testbench

Valid/ready FIFO controller that owns both ports of an external 64x256 two-port RAM with a registered read address (write on clk edge, read address captured on re, dout combinational from the captured address).
Turns a pipe-in/pipe-out data stream into RAM writes and prefetched RAM reads.
Sits between an upstream producer and a downstream consumer in the core clock domain; the RAM instance lives beside it.

---
 rtl/nv_ram_rws_fifo_ctrl_64x256.sv | 118 +++++++++++
 tb/tb_nv_ram_rws_fifo_ctrl_64x256.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/nv_ram_rws_fifo_ctrl_64x256.sv
// Valid/ready FIFO controller driving an external 64x256 two-port RAM with a
// registered read address. Writes go straight to RAM; reads are prefetched into
// the RAM output so that out_pd is ram_dout.
// Optional feature macro: NV_RAM_FIFO_WATERMARK_EN adds fifo_occ / fifo_hwm ports.
module nv_ram_rws_fifo_ctrl_64x256 #(
    parameter int unsigned DW    = 256,
    parameter int unsigned AW    = 6,
    parameter int unsigned DEPTH = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_pvld,
    output logic          in_prdy,
    input  logic [DW-1:0] in_pd,
    output logic          out_pvld,
    input  logic          out_prdy,
    output logic [DW-1:0] out_pd,
    output logic [AW-1:0] ram_wa,
    output logic          ram_we,
    output logic [DW-1:0] ram_di,
    output logic [AW-1:0] ram_ra,
    output logic          ram_re,
    input  logic [DW-1:0] ram_dout,
    input  logic [31:0]   pwrbus_ram_pd,
`ifdef NV_RAM_FIFO_WATERMARK_EN
    output logic [AW:0]   fifo_occ,
    output logic [AW:0]   fifo_hwm,
`endif
    output logic [31:0]   ram_pwrbus_ram_pd
);

    localparam logic [AW:0]   FullCnt = DEPTH[AW:0];
    localparam logic [AW:0]   CntOne  = 1;
    localparam logic [AW-1:0] PtrOne  = 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   occ_q, occ_d;    // written, not yet popped (includes presented entry)
    logic [AW:0]   pend_q, pend_d;  // written, not yet fetched
    logic          out_pvld_q, out_pvld_d;
    logic          push, fetch, pop;

    // Handshakes and RAM port drive; no bypass when full, even if popping.
    always_comb begin
        in_prdy           = !rst && (occ_q < FullCnt);
        push              = in_pvld && in_prdy;
        fetch             = (pend_q != '0) && (!out_pvld_q || out_prdy) && !rst;
        pop               = out_pvld_q && out_prdy;
        ram_we            = push;
        ram_wa            = wr_ptr_q;
        ram_di            = in_pd;
        ram_re            = fetch;
        ram_ra            = rd_ptr_q;
        out_pvld          = out_pvld_q;
        out_pd            = ram_dout;
        ram_pwrbus_ram_pd = pwrbus_ram_pd;
    end

    // Next-state for pointers and counters.
    always_comb begin
        wr_ptr_d   = push  ? wr_ptr_q + PtrOne : wr_ptr_q;
        rd_ptr_d   = fetch ? rd_ptr_q + PtrOne : rd_ptr_q;
        out_pvld_d = fetch || (out_pvld_q && !out_prdy);
        occ_d      = occ_q;
        pend_d     = pend_q;
        unique case ({push, pop})
            2'b10:   occ_d = occ_q + CntOne;
            2'b01:   occ_d = occ_q - CntOne;
            default: occ_d = occ_q;
        endcase
        unique case ({push, fetch})
            2'b10:   pend_d = pend_q + CntOne;
            2'b01:   pend_d = pend_q - CntOne;
            default: pend_d = pend_q;
        endcase
    end

    // State registers with synchronous reset; reset discards all contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            pend_q     <= '0;
            out_pvld_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            pend_q     <= pend_d;
            out_pvld_q <= out_pvld_d;
        end
    end

`ifdef NV_RAM_FIFO_WATERMARK_EN
    logic [AW:0] hwm_q;

    // Sticky maximum occupancy since reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            hwm_q <= '0;
        end else if (occ_q > hwm_q) begin
            hwm_q <= occ_q;
        end
    end

    assign fifo_occ = occ_q;
    assign fifo_hwm = hwm_q;
`endif

`ifndef SYNTHESIS
    a_occ_max: assert property (@(posedge clk) disable iff (rst) occ_q <= FullCnt);
    a_pend_le_occ: assert property (@(posedge clk) disable iff (rst) pend_q <= occ_q);
    a_occ_pend: assert property (@(posedge clk) disable iff (rst)
        (occ_q - pend_q) == {{AW{1'b0}}, out_pvld_q});
`endif

endmodule

// File: tb/tb_nv_ram_rws_fifo_ctrl_64x256.sv
// Self-checking bench: directed phases plus random traffic, checked each cycle
// against a queue-based model of accepted words and their earliest display time.
module tb_nv_ram_rws_fifo_ctrl_64x256;

    localparam int DW = 256;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_pvld;
    logic          in_prdy;
    logic [DW-1:0] in_pd;
    logic          out_pvld;
    logic          out_prdy;
    logic [DW-1:0] out_pd;
    logic [AW-1:0] ram_wa;
    logic          ram_we;
    logic [DW-1:0] ram_di;
    logic [AW-1:0] ram_ra;
    logic          ram_re;
    logic [DW-1:0] ram_dout;
    logic [31:0]   pwrbus_ram_pd;
    logic [31:0]   ram_pwrbus_ram_pd;
`ifdef NV_RAM_FIFO_WATERMARK_EN
    logic [AW:0]   fifo_occ;
    logic [AW:0]   fifo_hwm;
`endif

    always #5 clk = ~clk;

    nv_ram_rws_fifo_ctrl_64x256 dut (
        .clk               (clk),
        .rst               (rst),
        .in_pvld           (in_pvld),
        .in_prdy           (in_prdy),
        .in_pd             (in_pd),
        .out_pvld          (out_pvld),
        .out_prdy          (out_prdy),
        .out_pd            (out_pd),
        .ram_wa            (ram_wa),
        .ram_we            (ram_we),
        .ram_di            (ram_di),
        .ram_ra            (ram_ra),
        .ram_re            (ram_re),
        .ram_dout          (ram_dout),
        .pwrbus_ram_pd     (pwrbus_ram_pd),
`ifdef NV_RAM_FIFO_WATERMARK_EN
        .fifo_occ          (fifo_occ),
        .fifo_hwm          (fifo_hwm),
`endif
        .ram_pwrbus_ram_pd (ram_pwrbus_ram_pd)
    );

    // RAM with registered read address.
    logic [DW-1:0] mem [64];
    logic [AW-1:0] ra_q = '0;
    always @(posedge clk) begin
        if (ram_we) mem[ram_wa] <= ram_di;
        if (ram_re) ra_q <= ram_ra;
    end
    assign ram_dout = mem[ra_q];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Model: accepted words in order, with their push cycle.
    logic [DW-1:0] q_d[$];
    int            q_t[$];
    int            cyc       = 0;
    int            last_pop  = -100;
    int            push_cnt  = 0;
    int            fetch_cnt = 0;

    // Head is presented once it is 2 cycles past its push and the previous head is gone.
    function automatic bit visible(input int t);
        if (q_d.size() == 0) return 1'b0;
        return (t >= q_t[0] + 2) && (t >= last_pop + 1);
    endfunction

    task automatic step(input bit r, input bit v, input logic [DW-1:0] d, input bit pr);
        bit exp_prdy, exp_vld, psh, pp, exp_re;
        rst      = r;
        in_pvld  = v;
        in_pd    = d;
        out_prdy = pr;
        pwrbus_ram_pd = $urandom;
        @(negedge clk);
        check("pwrbus", {224'b0, ram_pwrbus_ram_pd}, {224'b0, pwrbus_ram_pd});
        if (r) begin
            check("rst_prdy", {255'b0, in_prdy}, '0);
            check("rst_we", {255'b0, ram_we}, '0);
            check("rst_re", {255'b0, ram_re}, '0);
            q_d.delete();
            q_t.delete();
            last_pop  = -100;
            push_cnt  = 0;
            fetch_cnt = 0;
        end else begin
            exp_prdy = (q_d.size() < 64);
            exp_vld  = visible(cyc);
            check("in_prdy", {255'b0, in_prdy}, {255'b0, exp_prdy});
            check("out_pvld", {255'b0, out_pvld}, {255'b0, exp_vld});
            if (exp_vld) check("out_pd", out_pd, q_d[0]);
            psh = v && exp_prdy;
            pp  = exp_vld && pr;
            check("ram_we", {255'b0, ram_we}, {255'b0, psh});
            if (psh) begin
                check("ram_wa", {250'b0, ram_wa}, DW'(push_cnt % 64));
                check("ram_di", ram_di, d);
            end
            if (pp) begin
                void'(q_d.pop_front());
                void'(q_t.pop_front());
                last_pop = cyc;
            end
            if (psh) begin
                q_d.push_back(d);
                q_t.push_back(cyc);
                push_cnt++;
            end
            exp_re = visible(cyc + 1) && (pp || !exp_vld);
            check("ram_re", {255'b0, ram_re}, {255'b0, exp_re});
            if (exp_re) begin
                check("ram_ra", {250'b0, ram_ra}, DW'(fetch_cnt % 64));
                fetch_cnt++;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rnd();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [DW-1:0] a5;
        a5 = {32{8'hA5}};
        @(posedge clk);
        #1;
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0);

        // Single word.
        step(1'b0, 1'b1, a5, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, 1'b1);

        // Fill with the consumer stalled.
        for (int i = 0; i < 70; i++) step(1'b0, 1'b1, DW'(i), 1'b0);

        // Drain while pushing, wrapping both pointers.
        for (int i = 0; i < 100; i++) step(1'b0, 1'b1, DW'(1000 + i), 1'b1);
        for (int i = 0; i < 70; i++) step(1'b0, 1'b0, '0, 1'b1);

        // Streaming.
        for (int i = 0; i < 200; i++) step(1'b0, 1'b1, DW'(5000 + i), 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, 1'b1);

        // Random traffic with back-pressure.
        for (int i = 0; i < 800; i++)
            step(1'b0, 1'($urandom_range(0, 3) != 0), rnd(), 1'($urandom_range(0, 1)));
        for (int i = 0; i < 70; i++) step(1'b0, 1'b0, '0, 1'b1);

        // Reset mid-stream with 10 entries held.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, rnd(), 1'b0);
        step(1'b1, 1'b1, rnd(), 1'b0);
        check("post_rst_vld", {255'b0, out_pvld}, '0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, DW'(9000 + i), 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
